// File: rtl/atm_pin_entry_if.sv
// ATM PIN-entry bundle: card/keypad inputs and verdict outputs.
// master drives card and keypad, slave is the PIN-entry stage.
interface atm_pin_entry_if;
  logic        card_valid;
  logic [7:0]  cardno;
  logic [15:0] stored_pin;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_clear;
  logic        busy;
  logic [2:0]  digit_count;
  logic [1:0]  tries_left;
  logic        pin_ok;
  logic        pin_bad;
  logic        timeout;
  logic        card_locked;

  modport master (
    output card_valid, cardno, stored_pin,
    output key_valid, key_digit, key_clear,
    input  busy, digit_count, tries_left,
    input  pin_ok, pin_bad, timeout, card_locked
  );

  modport slave (
    input  card_valid, cardno, stored_pin,
    input  key_valid, key_digit, key_clear,
    output busy, digit_count, tries_left,
    output pin_ok, pin_bad, timeout, card_locked
  );
endinterface

// File: rtl/atm_pin_entry.sv
// Keypad PIN collection and check with retry limit,
// inactivity timeout and card lock.
module atm_pin_entry #(
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  atm_pin_entry_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_DONE,
    S_LOCKED
  } state_e;

  state_e state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [15:0] pin_q, pin_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  tries_q, tries_d;
  logic [TW-1:0] timer_q, timer_d;
  logic busy_q, busy_d;
  logic ok_q, ok_d;
  logic bad_q, bad_d;
  logic to_q, to_d;
  logic lock_q, lock_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      pin_q   <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
      to_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      pin_q   <= pin_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      to_q    <= to_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    pin_d   = pin_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    timer_d = timer_q;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    to_d    = 1'b0;
    lock_d  = lock_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.card_valid && bus.cardno != 8'd0) begin
          state_d = S_ENTRY;
          pin_d   = bus.stored_pin;
          tries_d = 2'(MAX_TRIES);
          entry_d = '0;
          cnt_d   = '0;
          timer_d = '0;
        end
      end
      S_ENTRY: begin
        if (!bus.card_valid) begin
          state_d = S_IDLE;
          entry_d = '0;
          cnt_d   = '0;
          timer_d = '0;
        end else if (bus.key_clear) begin
          entry_d = '0;
          cnt_d   = '0;
          timer_d = '0;
        end else if (bus.key_valid && bus.key_digit <= 4'd9) begin
          entry_d = {entry_q[11:0], bus.key_digit};
          cnt_d   = cnt_q + 3'd1;
          timer_d = '0;
          if (cnt_q == 3'd3) state_d = S_CHECK;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // silent cycles, including rejected non-BCD keys, run out
          to_d    = 1'b1;
          state_d = S_IDLE;
          entry_d = '0;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (!bus.card_valid) begin
          state_d = S_IDLE;
          entry_d = '0;
          cnt_d   = '0;
          timer_d = '0;
        end else if (entry_q == pin_q) begin
          state_d = S_DONE;
          ok_d    = 1'b1;
        end else if (tries_q > 2'd1) begin
          state_d = S_ENTRY;
          tries_d = tries_q - 2'd1;
          bad_d   = 1'b1;
          entry_d = '0;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          state_d = S_LOCKED;
          tries_d = '0;
          bad_d   = 1'b1;
          lock_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (!bus.card_valid) state_d = S_IDLE;
      end
      S_LOCKED: begin
        lock_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_ENTRY) || (state_d == S_CHECK);
  end

  assign bus.busy        = busy_q;
  assign bus.digit_count = cnt_q;
  assign bus.tries_left  = tries_q;
  assign bus.pin_ok      = ok_q;
  assign bus.pin_bad     = bad_q;
  assign bus.timeout     = to_q;
  assign bus.card_locked = lock_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Scoreboard bench for atm_pin_entry: expected pulses are
// queued by stimulus and matched by a negedge monitor.
module tb_atm_pin_entry;

  localparam int T = 16;

  typedef struct {
    logic [2:0] pulses;
    int         cyc;
    logic [1:0] tries;
    logic       lock;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  atm_pin_entry_if bus();

  atm_pin_entry #(
    .MAX_TRIES(3),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] p, input int c,
                      input logic [1:0] tr, input logic lk);
    exp_t e;
    e.pulses = p;
    e.cyc    = c;
    e.tries  = tr;
    e.lock   = lk;
    sb.push_back(e);
  endtask

  // {pin_ok, pin_bad, timeout}
  always @(negedge clk) begin
    logic [2:0] p;
    exp_t e;
    p = {bus.pin_ok, bus.pin_bad, bus.timeout};
    if (p != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", int'(p), 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", int'(p), int'(e.pulses));
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_tries", int'(bus.tries_left), int'(e.tries));
        chk("pulse_lock", int'(bus.card_locked), int'(e.lock));
      end
    end
  end

  task automatic step(input logic kv, input logic [3:0] kd,
                      input logic kc);
    bus.key_valid = kv;
    bus.key_digit = kd;
    bus.key_clear = kc;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.key_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic start(input logic [15:0] pin);
    bus.card_valid = 1'b1;
    bus.cardno     = 8'd42;
    bus.stored_pin = pin;
    idle(1);
  endtask

  task automatic drop_card();
    bus.card_valid = 1'b0;
    bus.cardno     = 8'd0;
    idle(1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, int'(bus.busy), 0);
    chk({nm, "_cnt"}, int'(bus.digit_count), 0);
    chk({nm, "_tries"}, int'(bus.tries_left), 0);
    chk({nm, "_pulses"},
        int'({bus.pin_ok, bus.pin_bad, bus.timeout}), 0);
    chk({nm, "_lock"}, int'(bus.card_locked), 0);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    key(a);
    key(b);
    key(c);
    key(d);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.card_valid = 1'b0;
    bus.cardno     = 8'd0;
    bus.stored_pin = 16'h0;
    bus.key_valid  = 1'b0;
    bus.key_digit  = 4'd0;
    bus.key_clear  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);
    chk("idle_nocard_busy", int'(bus.busy), 0);

    // correct PIN on first attempt
    start(16'h1234);
    chk("start_busy", int'(bus.busy), 1);
    chk("start_tries", int'(bus.tries_left), 3);
    chk("start_cnt", int'(bus.digit_count), 0);
    key(4'd1);
    key(4'd2);
    key(4'd3);
    chk("cnt3", int'(bus.digit_count), 3);
    push(3'b100, cyc + 2, 2'd3, 1'b0);
    key(4'd4);
    chk("cnt4", int'(bus.digit_count), 4);
    chk("check_busy", int'(bus.busy), 1);
    idle(3);
    chk("done_busy", int'(bus.busy), 0);
    chk("done_tries", int'(bus.tries_left), 3);
    drop_card();
    idle(1);
    chk("after_done_busy", int'(bus.busy), 0);

    // clear handling, clear beats key, non-BCD ignored, PIN latched
    start(16'h1234);
    bus.stored_pin = 16'h9999;
    key(4'd9);
    chk("cnt_after_9", int'(bus.digit_count), 1);
    step(1'b0, 4'd0, 1'b1);
    chk("cnt_after_clear", int'(bus.digit_count), 0);
    key(4'd5);
    step(1'b1, 4'd7, 1'b1);
    chk("cnt_clear_wins", int'(bus.digit_count), 0);
    key(4'hA);
    chk("cnt_nonbcd", int'(bus.digit_count), 0);
    key(4'd1);
    key(4'd2);
    key(4'd3);
    push(3'b100, cyc + 2, 2'd3, 1'b0);
    key(4'd4);
    idle(3);
    drop_card();
    idle(1);

    // inactivity timeout after two digits
    start(16'h1234);
    key(4'd1);
    push(3'b001, cyc + 1 + T, 2'd3, 1'b0);
    key(4'd2);
    idle(T - 1);
    chk("pre_timeout_busy", int'(bus.busy), 1);
    idle(1);
    chk("timeout_busy", int'(bus.busy), 0);
    chk("timeout_cnt", int'(bus.digit_count), 0);
    drop_card();
    idle(2);
    chk("timeout_idle_busy", int'(bus.busy), 0);

    // three wrong attempts lock the card
    start(16'h1234);
    push(3'b010, cyc + 5, 2'd2, 1'b0);
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    idle(1);
    chk("bad1_busy", int'(bus.busy), 1);
    chk("bad1_cnt", int'(bus.digit_count), 0);
    push(3'b010, cyc + 5, 2'd1, 1'b0);
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    idle(1);
    push(3'b010, cyc + 5, 2'd0, 1'b1);
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    idle(2);
    chk("locked", int'(bus.card_locked), 1);
    chk("locked_busy", int'(bus.busy), 0);
    drop_card();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("locked_after_removal", int'(bus.card_locked), 1);
    chk("locked_tries", int'(bus.tries_left), 0);
    rst = 1'b1;
    #1;
    chk_all_zero("reset_locked");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // card removal mid-entry: no pulses
    start(16'h1234);
    key(4'd1);
    key(4'd2);
    key(4'd3);
    drop_card();
    chk("removal_busy", int'(bus.busy), 0);
    chk("removal_cnt", int'(bus.digit_count), 0);
    idle(3);

    // reset while in CHECK
    start(16'h1234);
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("in_check_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("reset_check");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drop_card();
    idle(4);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_pin_entry.md
# atm_pin_entry

Keypad PIN-entry and verification stage placed directly upstream of the ATM transaction controller. It collects four BCD digits from the keypad after a card is inserted and compares them against the stored PIN for that card. It enforces a retry limit and an inactivity timeout. It emits a one-cycle `pin_ok` pulse that the transaction controller consumes to leave its PIN state, and it locks the card after repeated failures.

## Interface
Parameters:
- `MAX_TRIES`, default 3: wrong-PIN attempts allowed before lock (1..3).
- `TIMEOUT_CYCLES`, default 16: consecutive cycles in ENTRY with no key event before the session is abandoned (≥2).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `card_valid`  in  1: level, high while a card is inserted.
- `cardno`  in  8: card number; a value of 0 means no card.
- `stored_pin`  in  16: the card's PIN as four BCD digits, most-significant digit first; sampled on session start.
- `key_valid`  in  1: one-cycle strobe qualifying `key_digit`.
- `key_digit`  in  4: keypad digit.
- `key_clear`  in  1: one-cycle strobe that erases the current entry.
- `busy`  out  1: high in ENTRY and CHECK.
- `digit_count`  out  3: digits accepted in the current attempt (0..4).
- `tries_left`  out  2: remaining attempts.
- `pin_ok`  out  1: one-cycle pulse, PIN matched.
- `pin_bad`  out  1: one-cycle pulse, PIN mismatched.
- `timeout`  out  1: one-cycle pulse, inactivity abort.
- `card_locked`  out  1: level, card retained.

## Operation
- States: IDLE, ENTRY, CHECK, DONE, LOCKED. All outputs are registered.
- **IDLE**
  - When `card_valid`=1 and `cardno`≠0: go to ENTRY, latch `stored_pin`, set `tries_left`=MAX_TRIES, clear the entry register, `digit_count` and timer.
- **ENTRY**
  - `key_clear`: entry=0, `digit_count`=0, timer=0. `key_clear` has priority over a simultaneous `key_valid`.
  - `key_valid` with `key_digit`≤9: entry = {entry[11:0], key_digit}, `digit_count`+1, timer=0.
  - `key_valid` with `key_digit`>9: ignored completely; it does not reset the timer.
  - When the 4th digit is accepted: go to CHECK on that edge. Further keys are ignored until back in ENTRY.
  - With no accepted key or clear, the timer increments each cycle. At timer = TIMEOUT_CYCLES−1: `timeout` pulses, go to IDLE.
- **CHECK** (exactly one cycle): compare entry against the latched PIN.
  - Match: go to DONE, `pin_ok` pulses.
  - Mismatch with `tries_left`>1: decrement `tries_left`, `pin_bad` pulses, return to ENTRY with entry, count and timer cleared.
  - Mismatch with `tries_left`=1: `tries_left`=0, `pin_bad` pulses, go to LOCKED, `card_locked`=1.
- **DONE**: hold, with `busy`=0, until `card_valid`=0, then go to IDLE.
- **LOCKED**: `card_locked` stays 1 regardless of inputs; only `rst` leaves this state.
- Card removal (`card_valid`=0) in ENTRY or CHECK: go to IDLE on the next edge. No `pin_ok`, `pin_bad` or `timeout` pulse is produced, and the entry is cleared.
- The latched PIN is never updated mid-session. `stored_pin` changes are ignored outside IDLE.

## Timing
- Reset (asynchronous): state=IDLE. `busy`, `digit_count`, `tries_left`, `pin_ok`, `pin_bad`, `timeout` and `card_locked` are all 0. The entry register, latched PIN and timer are cleared.
- Reset asserted mid-session aborts it immediately, including from LOCKED.
- Card-detect to ENTRY (`busy`=1): 1 edge.
- 4th `key_valid` sampled at edge N: CHECK during cycle N→N+1. `pin_ok`/`pin_bad` are high for the cycle after edge N+1; the verdict latency is 2 edges.
- Pulse outputs are high for exactly one cycle and are mutually exclusive.
- Timeout fires exactly TIMEOUT_CYCLES idle cycles after entering ENTRY or after the last accepted key/clear.
- `digit_count` and `tries_left` update on the same edge as the event that changes them.

## Test plan
- PIN 0x1234, keys 1,2,3,4 on consecutive cycles → `pin_ok` pulses 2 edges after key 4, `tries_left`=3, state DONE. Dropping `card_valid` → IDLE.
- Enter 1,2,3,5 three times with MAX_TRIES=3 → `pin_bad` pulses three times, `tries_left` goes 2, 1, 0, then `card_locked`=1. Removing the card leaves `card_locked`=1; `rst` clears it.
- Keys 9, then clear, then 1,2,3,4; also a key_clear+key_valid in the same cycle, and `key_digit`=0xA → the clear wins, 0xA is not counted, and the final result is `pin_ok`.
- Enter 1,2 then idle for TIMEOUT_CYCLES=16 cycles → `timeout` pulses on the 16th idle cycle, state IDLE, no `pin_bad`.
- Enter 1,2,3 then drop `card_valid` → IDLE next edge with no pulses. Assert `rst` during CHECK → all outputs 0 immediately.
